// File: rtl/dmem_sized.sv
// Handshaked byte-addressed data memory with sized/extended loads, alignment and range errors, and zero-fill after reset.
// Latency: response strobe WAIT_STATES+1 cycles after acceptance; no response backpressure, ready low during INIT/WAIT.
module dmem_sized #(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   init_cnt;
    logic [3:0]         wait_cnt;

    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [1:0]         r_size;
    logic               r_uns;

    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               enter_resp;

    logic               a_we;
    logic [ADDR_W-1:0]  a_addr;
    logic [31:0]        a_wdata;
    logic [1:0]         a_size;
    logic               a_uns;

    logic [IDX_W-1:0]   idx;
    logic [1:0]         off;
    logic               range_err;
    logic               err;
    logic [31:0]        wlanes;
    logic [3:0]         be;
    logic [31:0]        rword;
    logic [15:0]        shifted;
    logic [31:0]        ld;

    assign accept = req_valid_i & req_ready_o;

    // With no wait states the array is accessed on the acceptance edge itself,
    // so the live request has to bypass the request registers.
    assign enter_resp = ((state == ST_WAIT) && (wait_cnt == 4'd0)) || (accept && NO_WAIT);

    assign a_we    = NO_WAIT ? req_we_i       : r_we;
    assign a_addr  = NO_WAIT ? req_addr_i     : r_addr;
    assign a_wdata = NO_WAIT ? req_wdata_i    : r_wdata;
    assign a_size  = NO_WAIT ? req_size_i     : r_size;
    assign a_uns   = NO_WAIT ? req_unsigned_i : r_uns;

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
                if (init_cnt == IDX_W'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    state_nxt = NO_WAIT ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready_o = (state == ST_IDLE) || (state == ST_RESP);
        rsp_valid_o = (state == ST_RESP);
    end

    // Address decode and error classification
    always_comb begin
        idx       = a_addr[IDX_W+1:2];
        off       = a_addr[1:0];
        range_err = (a_addr >> (IDX_W + 2)) != '0;
        err       = range_err
                  || (a_size == 2'b11)
                  || ((a_size == 2'b01) && off[0])
                  || ((a_size == 2'b10) && (off != 2'b00));
    end

    // Store lane replication and byte enables
    always_comb begin
        wlanes = a_wdata;
        be     = 4'hF;
        case (a_size)
            2'b00: begin
                wlanes = {4{a_wdata[7:0]}};
                be     = 4'b0001 << off;
            end
            2'b01: begin
                wlanes = {2{a_wdata[15:0]}};
                be     = 4'b0011 << off;
            end
            default: begin
                wlanes = a_wdata;
                be     = 4'hF;
            end
        endcase
    end

    // Load lane selection and extension
    always_comb begin
        rword   = mem[idx];
        shifted = 16'(rword >> {off, 3'b000});
        case (a_size)
            2'b00:   ld = {{24{~a_uns & shifted[7]}}, shifted[7:0]};
            2'b01:   ld = {{16{~a_uns & shifted[15]}}, shifted[15:0]};
            default: ld = rword;
        endcase
    end

    // Storage array is cleared by the INIT sweep rather than by reset
    always_ff @(posedge clk_i) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
        end else if (enter_resp && a_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

    // Counters, request capture and registered response
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            init_cnt    <= '0;
            wait_cnt    <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            init_cnt <= (state == ST_INIT) ? init_cnt + 1'b1 : '0;
            if (accept) begin
                r_we     <= req_we_i;
                r_addr   <= req_addr_i;
                r_wdata  <= req_wdata_i;
                r_size   <= req_size_i;
                r_uns    <= req_unsigned_i;
                wait_cnt <= WAIT_LOAD;
            end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_err_o   <= err;
                rsp_rdata_o <= (err || a_we) ? 32'd0 : ld;
            end
        end
    end

endmodule

// File: tb/tb_dmem_sized.sv
// Randomised self-checking bench for dmem_sized: a WAIT_STATES=3 instance for timing/function and a
// WAIT_STATES=0 instance for streaming throughput, both checked against a byte-array reference model.
module tb_dmem_sized;
    localparam int DEPTH = 32;
    localparam int WS    = 3;
    localparam int NBYTE = DEPTH * 4;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_ready, a_we, a_uns, a_rvalid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [1:0]  a_size;

    logic        b_valid, b_ready, b_we, b_uns, b_rvalid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [1:0]  b_size;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [2][NBYTE];

    dmem_sized #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(WS)) u_dut_a (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we),
        .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_size_i(a_size),
        .req_unsigned_i(a_uns), .rsp_valid_o(a_rvalid), .rsp_rdata_o(a_rdata),
        .rsp_err_o(a_err)
    );

    dmem_sized #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(0)) u_dut_b (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_size_i(b_size),
        .req_unsigned_i(b_uns), .rsp_valid_o(b_rvalid), .rsp_rdata_o(b_rdata),
        .rsp_err_o(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NBYTE; i++) mem_m[d][i] = 8'h00;
    endtask

    // Reference behaviour: memory as a flat byte array, access width 1<<size bytes
    task automatic model(input int d, input logic we, input logic [31:0] addr, wdata,
                         input logic [1:0] size, input logic uns,
                         output logic [31:0] rd, output logic e);
        int n;
        longint unsigned v;
        n  = 1 << size;
        e  = (addr >= NBYTE) || (size == 2'b11) || ((addr % n) != 0);
        rd = 32'd0;
        if (e) return;
        if (we) begin
            for (int i = 0; i < n; i++) mem_m[d][addr + i] = wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (longint'(mem_m[d][addr + i]) << (8 * i));
            if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 1);
            rd = v[31:0];
        end
    endtask

    // Issue one request on DUT A and follow it to its response, checking handshake timing.
    // Returns positioned at the negedge inside the response cycle.
    task automatic a_xact(input logic we, input logic [31:0] addr, wdata, input logic [1:0] size,
                          input logic uns, output logic [31:0] rd, output logic e, output int waited);
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_size = size; a_uns = uns;
        waited = 0;
        while (a_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: ready=%b required 1", a_ready);
            a_valid = 1'b0; rd = 'x; e = 'x;
            return;
        end
        @(negedge clk);
        a_valid = 1'b0;
        for (int i = 1; i <= WS; i++) begin
            checks++;
            if (a_rvalid !== 1'b0 || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL wait_quiet: cycle %0d rsp_valid=%b ready=%b required 0/0", i, a_rvalid, a_ready);
            end
            // junk presented while not ready must be ignored
            a_valid = 1'($urandom_range(0, 1)); a_we = 1'($urandom);
            a_addr = $urandom_range(0, NBYTE - 1); a_wdata = $urandom;
            a_size = 2'($urandom); a_uns = 1'($urandom);
            @(negedge clk);
        end
        a_valid = 1'b0;
        checks++;
        if (a_rvalid !== 1'b1 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp_strobe: rsp_valid=%b ready=%b required 1/1", a_rvalid, a_ready);
        end
        rd = a_rdata;
        e  = a_err;
    endtask

    task automatic a_run(input string nm, input logic we, input logic [31:0] addr, wdata,
                         input logic [1:0] size, input logic uns, output logic [31:0] rd);
        logic [31:0] erd;
        logic ee, e;
        int w;
        model(0, we, addr, wdata, size, uns, erd, ee);
        a_xact(we, addr, wdata, size, uns, rd, e, w);
        checks++;
        if (rd !== erd || e !== ee) begin
            errors++;
            $display("FAIL %s: rdata=%h err=%b required rdata=%h err=%b", nm, rd, e, erd, ee);
        end
    endtask

    task automatic watch_init(input string nm);
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            checks++;
            if (a_ready !== (i == DEPTH) || a_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL %s: cycle %0d ready=%b rsp_valid=%b required %b/0", nm, i, a_ready, a_rvalid, (i == DEPTH));
            end
        end
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_b: ready=%b required 1", nm, b_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_size = 0; a_uns = 0;
        b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_size = 0; b_uns = 0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if (a_ready !== 1'b0 || a_rvalid !== 1'b0 || a_rdata !== 32'd0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b required 0/0/0/0",
                     a_ready, a_rvalid, a_rdata, a_err);
        end
        rst_n = 1'b1;
        watch_init("init_ready");
    endtask

    task automatic test_init_zero();
        logic [31:0] rd;
        for (int w = 0; w < DEPTH; w++) a_run("init_zero", 1'b0, 32'(w * 4), 32'd0, 2'b10, 1'b0, rd);
    endtask

    task automatic test_store_bytes();
        logic [31:0] rd;
        a_run("st_word", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd);
        a_run("st_byte", 1'b1, 32'h12, 32'h0000007F, 2'b00, 1'b0, rd);
        a_run("ld_word", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd);
        checks++;
        if (rd !== 32'hDE7FBEEF) begin errors++; $display("FAIL merged_word: got %h required DE7FBEEF", rd); end
        a_run("ld_sbyte", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd);
        checks++;
        if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL signed_byte: got %h required FFFFFFDE", rd); end
        a_run("ld_ubyte", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd);
        checks++;
        if (rd !== 32'h000000DE) begin errors++; $display("FAIL unsigned_byte: got %h required 000000DE", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd;
        a_run("st_half", 1'b1, 32'h06, 32'h12348001, 2'b01, 1'b0, rd);
        a_run("ld_shalf", 1'b0, 32'h06, 32'h0, 2'b01, 1'b0, rd);
        checks++;
        if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL signed_half: got %h required FFFF8001", rd); end
        a_run("ld_uhalf", 1'b0, 32'h06, 32'h0, 2'b01, 1'b1, rd);
        checks++;
        if (rd !== 32'h00008001) begin errors++; $display("FAIL unsigned_half: got %h required 00008001", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic [31:0] eaddr [4] = '{32'h02, 32'h01, 32'h04, 32'h80};
        logic [1:0]  esize [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] erd;
        logic        ee, e;
        int          w;
        for (int k = 0; k < 4; k++) begin
            for (int we = 0; we < 2; we++) begin
                model(0, 1'(we), eaddr[k], 32'hFFFFFFFF, esize[k], 1'b0, erd, ee);
                a_xact(1'(we), eaddr[k], 32'hFFFFFFFF, esize[k], 1'b0, rd, e, w);
                checks++;
                if (e !== 1'b1 || rd !== 32'd0) begin
                    errors++;
                    $display("FAIL err_resp: case %0d we=%0d err=%b rdata=%h required 1/00000000", k, we, e, rd);
                end
            end
        end
        for (int wd = 0; wd < 6; wd++) a_run("err_readback", 1'b0, 32'(wd * 4), 32'h0, 2'b10, 1'b0, rd);
    endtask

    task automatic test_back_to_back_ws3();
        logic [31:0] rd;
        logic e;
        int w;
        a_xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, e, w);
        a_xact(1'b0, 32'h04, 32'h0, 2'b10, 1'b0, rd, e, w);
        checks++;
        if (w !== 0) begin errors++; $display("FAIL b2b_accept: waited %0d cycles required 0", w); end
    endtask

    task automatic test_midop_reset();
        logic [31:0] rd;
        a_run("pre_reset_load", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h04; a_wdata = 32'h12345678; a_size = 2'b10; a_uns = 1'b0;
        @(negedge clk);
        a_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b0 || a_rvalid !== 1'b0 || a_rdata !== 32'd0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ready=%b valid=%b rdata=%h err=%b required 0/0/0/0",
                     a_ready, a_rvalid, a_rdata, a_err);
        end
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        watch_init("reinit");
        a_run("post_reset_load", 1'b0, 32'h04, 32'h0, 2'b10, 1'b0, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL discarded_store: got %h required 00000000", rd); end
    endtask

    task automatic rand_req(output logic we, output logic [31:0] addr, wdata,
                            output logic [1:0] size, output logic uns);
        we    = 1'($urandom_range(0, 1));
        size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(NBYTE, NBYTE + 64)) : 32'($urandom_range(0, 31));
        if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << size) - 1);
        wdata = $urandom;
        uns   = 1'($urandom_range(0, 1));
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata;
        logic we, uns;
        logic [1:0] size;
        for (int i = 0; i < 60; i++) begin
            rand_req(we, addr, wdata, size, uns);
            a_run("random_a", we, addr, wdata, size, uns, rd);
        end
    endtask

    task automatic test_back_to_back_ws0();
        logic [31:0] erd, addr, wdata;
        logic ee, we, uns;
        logic [1:0] size;
        for (int i = 0; i < 80; i++) begin
            rand_req(we, addr, wdata, size, uns);
            model(1, we, addr, wdata, size, uns, erd, ee);
            b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_size = size; b_uns = uns;
            checks++;
            if (b_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: ready=%b required 1", b_ready); end
            @(negedge clk);
            checks++;
            if (b_rvalid !== 1'b1 || b_rdata !== erd || b_err !== ee) begin
                errors++;
                $display("FAIL stream_resp: req %0d valid=%b rdata=%h err=%b required 1/%h/%b",
                         i, b_rvalid, b_rdata, b_err, erd, ee);
            end
        end
        b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b_rvalid !== 1'b0) begin errors++; $display("FAIL stream_idle: valid=%b required 0", b_rvalid); end
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_store_bytes();
        test_half();
        test_errors();
        test_back_to_back_ws3();
        test_midop_reset();
        test_random();
        test_back_to_back_ws0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

- Parametrised, handshaked data memory for the RISC-V core's load/store path.
- Byte-addressed, with byte/half/word stores placed into the correct lanes from the address offset.
- Sign/zero-extending loads.
- Alignment and range error responses.
- Configurable wait states.
- Self-clearing initialisation sequence after reset.

## Interface
Parameters:
- DEPTH, 32, number of 32-bit words; power of two, ≥ 2
- ADDR_W, 32, byte-address width; must satisfy ADDR_W ≥ log2(DEPTH)+2
- WAIT_STATES, 0, extra cycles between acceptance and response; legal range 0..15

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  request can be accepted this cycle
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_rdata_o  out  32  load result; 0 for stores and errors
- rsp_err_o  out  1  access rejected; qualified by rsp_valid_o

## Operation
States: INIT, IDLE, WAIT, RESP.

INIT
- Entered on reset; remains after reset release.
- Writes 0 to word index 0, 1, … DEPTH-1, one word per cycle, using an init counter.
- Moves to IDLE after writing index DEPTH-1.
- req_ready_o = 0 throughout.

IDLE
- req_ready_o = 1.
- On req_valid_i && req_ready_o, captures we, addr, wdata, size and unsigned into request registers.
- Goes to WAIT if WAIT_STATES > 0, else to RESP.

WAIT
- A down-counter loaded with WAIT_STATES-1 at acceptance.
- Goes to RESP when the counter is 0.
- req_ready_o = 0.

RESP
- rsp_valid_o = 1 for exactly this cycle.
- req_ready_o = 1: a request accepted here goes straight to WAIT/RESP, otherwise the block returns to IDLE.
- No response backpressure; the consumer must take the response in this cycle.

Address decode
- Word index = addr[log2(DEPTH)+1:2]; offset o = addr[1:0].
- Error (err = 1) if any of:
  - addr ≥ 4·DEPTH
  - size = 11
  - half access with o[0] = 1
  - word access with o ≠ 00
- An erroring store does not modify memory; an erroring load returns rdata = 0.

Stores (legal)
- byte: lane o ← wdata[7:0]
- half: lanes o+1:o ← wdata[15:0]
- word: all lanes ← wdata
- Other lanes keep their old value.
- rdata = 0.

Loads (legal)
- byte: lane o extended from bit 7
- half: lanes o+1:o extended from bit 15
- word: returned unmodified
- Extension is zero-extend if unsigned = 1, else sign-extend.

## Timing
- Reset values: req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0; state = INIT; counters = 0.
- First acceptance possible DEPTH cycles after reset release.
- Latency: request accepted at edge k → rsp_valid_o high in the cycle after edge k+WAIT_STATES.
- Array access:
  - Both the array write and the registered load read happen on the edge that enters RESP.
  - The read uses the array contents before that edge, so a load sees every store whose response has already been given.
- Throughput:
  - WAIT_STATES = 0 and requests held continuously valid: one response every cycle.
  - Otherwise one response per WAIT_STATES+1 cycles.
- rsp_rdata_o and rsp_err_o:
  - Registered.
  - Hold their value until the next response.
  - Meaningful only while rsp_valid_o = 1.
- Reset asserted mid-operation:
  - All outputs return to reset values immediately (asynchronously).
  - The in-flight request is discarded: no write, no response.
  - INIT reruns after reset release.
- Inputs are ignored while req_ready_o = 0.

## Test plan
- Reset release, DEPTH = 32 → req_ready_o rises exactly 32 cycles later. A word load of every address returns 0 with err = 0.
- Word store 0xDEADBEEF @0x10, then byte store 0x7F @0x12 → word load @0x10 = 0xDE7FBEEF. Signed byte load @0x13 = 0xFFFFFFDE; unsigned = 0x000000DE.
- Half store 0x8001 @0x06, then signed half load @0x06 → 0xFFFF8001. Unsigned half load @0x06 → 0x00008001.
- Misaligned word @0x02, half @0x01, size 11, and address 0x80 (DEPTH = 32) → each gets rsp_err_o = 1, rdata = 0. Memory is unchanged on read-back.
- WAIT_STATES = 3, accept at edge k → rsp_valid_o high only in the cycle after edge k+3. req_ready_o = 0 in between; a back-to-back request is accepted during RESP.
- Assert reset_ni low during WAIT after a store to @0x04 → no response. After reinit, load @0x04 returns 0.
